// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH add/shift cycles through a chain of 4-bit CLA groups.
// Optional two's complement operands when SEQ_MULTIPLIER_SIGNED_EN is defined.

module seq_multiplier_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // All group carries are computed directly from generate/propagate terms
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int NG = WIDTH / 4;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum_lo;
  logic [NG:0]        carry;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] result;

  assign addend   = mplier[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NG; gi++) begin : g_cla
    seq_multiplier_cla4 u_cla (
      .a    (acc_hi[4*gi +: 4]),
      .b    (addend[4*gi +: 4]),
      .cin  (carry[gi]),
      .s    (sum_lo[4*gi +: 4]),
      .cout (carry[gi+1])
    );
  end

  // Carry-out of the top group becomes the new top bit of the accumulator
  assign sum  = {carry[NG], sum_lo};
  assign step = {sum, mplier[WIDTH-1:1]};

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic             neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign result = neg ? (~step + 1'b1) : step;
`else
  assign result = step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product is written only on the final iteration, so it holds through the next RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`else
            mcand  <= a;
            mplier <= b;
`endif
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          {acc_hi, mplier} <= step;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST) product <= result;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = !ready;
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, handshake corner cases and
// randomized operands against an arithmetic reference model.

module tb_seq_multiplier;

  localparam int W = 16;
  localparam int LAT = W + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int compared;
  int mismatched;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_u;
    logic [2*W-1:0] exp_s;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe;
    logic [2*W-1:0] ye;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
`else
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
`endif
    return xe * ye;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for ready, issues one start pulse and returns the product at the done cycle
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               output logic [2*W-1:0] prod, output int lat, output bit hsOk);
    int guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    hsOk = 1'b1;
    prod = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        prod = product;
        break;
      end
      if (ready || !busy) hsOk = 1'b0;
    end
  endtask

  initial begin
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    logic [2*W-1:0] held;
    int lat;
    int gap;
    bit hsOk;
    bit sawDone;
    bit stable;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    compared   = 0;
    mismatched = 0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 32'h00000000};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000, 32'h00000000};
    vecs[4] = '{16'hFFFD, 16'h0005, 32'h0004FFF1, 32'hFFFFFFF1};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 32'hFFFFFFFF};
    vecs[7] = '{16'h8000, 16'h0001, 32'h00008000, 32'hFFFF8000};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      exp = vecs[i].exp_s;
`else
      exp = vecs[i].exp_u;
`endif
      applyStimulus(vecs[i].a, vecs[i].b, prod, lat, hsOk);
      checkOutput($sformatf("vec%0d_product", i), 64'(prod), 64'(exp));
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      checkOutput($sformatf("vec%0d_busy_handshake", i), 64'(hsOk), 64'd1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d_ready_back", i), 64'(ready), 64'd1);
    end

    // A start pulse in the middle of a run must be ignored
    a = 16'd2;
    b = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    prod = '0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      lat = i;
      if (i == 5) begin
        a = 16'd7;
        b = 16'd7;
        start = 1'b1;
      end
      if (i == 6) start = 1'b0;
      if (done) begin
        prod = product;
        break;
      end
    end
    checkOutput("ignored_start_product", 64'(prod), 64'h4);
    checkOutput("ignored_start_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    applyStimulus(16'd7, 16'd7, prod, lat, hsOk);
    checkOutput("after_ignored_product", 64'(prod), 64'h31);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0101;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_ready", 64'(ready), 64'd1);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || !ready) sawDone = 1'b1;
    end
    checkOutput("midreset_no_done", 64'(sawDone), 64'd0);
    applyStimulus(16'h00FF, 16'h0101, prod, lat, hsOk);
    checkOutput("after_reset_product", 64'(prod), 64'(refModel(16'h00FF, 16'h0101)));
    checkOutput("after_reset_latency", 64'(lat), 64'(LAT));

    // start held high: back-to-back accepts, product held through the next run
    @(negedge clk);
    a = 16'h0011;
    b = 16'h0022;
    start = 1'b1;
    held = '0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        held = product;
        sawDone = 1'b1;
        break;
      end
    end
    checkOutput("held_first_done", 64'(sawDone), 64'd1);
    checkOutput("held_first_product", 64'(held), 64'h242);
    a = 16'h0003;
    b = 16'h0003;
    gap = 0;
    stable = 1'b1;
    prod = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      gap = i;
      if (done) begin
        prod = product;
        break;
      end
      if (product !== held) stable = 1'b0;
    end
    start = 1'b0;
    checkOutput("held_gap", 64'(gap), 64'(LAT + 1));
    checkOutput("held_product_stable", 64'(stable), 64'd1);
    checkOutput("held_second_product", 64'(prod), 64'h9);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 6 == 0) ra = {1'b1, {(W-1){1'b0}}};
      if (i % 6 == 1) rb = '1;
      applyStimulus(ra, rb, prod, lat, hsOk);
      checkOutput($sformatf("rand%0d_%0h_x_%0h", i, ra, rb), 64'(prod), 64'(refModel(ra, rb)));
      if (lat != LAT) checkOutput($sformatf("rand%0d_latency", i), 64'(lat), 64'(LAT));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
